// File: rtl/updown_counter_n.sv
// Parametrised single-clock up/down counter: modulus, parallel load, sync clear, cascade carry/borrow.
// Define UDCNT_SAT_EN for saturating arithmetic; by default the count wraps around.
module updown_counter_n #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ce,
    input  logic             up,
    input  logic             dn,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             bo,
    output logic             wrap,
    output logic             sat
);

    // MODULUS may be 2**32 for WIDTH=32, so the bound is formed in 64 bits then narrowed.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             step_up, step_dn;
    logic             at_max, at_min;

    assign step_up = ce & up & ~dn;
    assign step_dn = ce & dn & ~up;
    assign at_max  = (q_q == MAX_Q);
    assign at_min  = (q_q == '0);

    // Carry/borrow stay combinational so a cascaded stage steps on the same edge.
    assign co = step_up & at_max;
    assign bo = step_dn & at_min;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        q_d    = q_q;
        wrap_d = 1'b0;
`ifdef UDCNT_SAT_EN
        sat_d  = sat_q;
`else
        sat_d  = 1'b0;
`endif
        if (clr) begin
            q_d   = '0;
            sat_d = 1'b0;
        end else if (load) begin
            q_d   = (d > MAX_Q) ? MAX_Q : d;
            sat_d = 1'b0;
        end else if (step_up) begin
            if (at_max) begin
`ifdef UDCNT_SAT_EN
                sat_d  = 1'b1;
`else
                q_d    = '0;
                wrap_d = 1'b1;
`endif
            end else begin
                q_d   = q_q + WIDTH'(1);
                sat_d = 1'b0;
            end
        end else if (step_dn) begin
            if (at_min) begin
`ifdef UDCNT_SAT_EN
                sat_d  = 1'b1;
`else
                q_d    = MAX_Q;
                wrap_d = 1'b1;
`endif
            end else begin
                q_d   = q_q - WIDTH'(1);
                sat_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_Q;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;

endmodule
